// File: rtl/axi_mem_traffic_chk_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : axi_mem_traffic_chk_pkg                                         |
// | Purpose  : Shared constants for the memory traffic generator/checker:      |
// |            pattern mode encodings, FSM state encodings and the LFSR        |
// |            polynomial/seed with its step function.                         |
// | Ports    : none (package)                                                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package axi_mem_traffic_chk_pkg;

    // Data pattern selection
    localparam logic [1:0] C_MODE_INCR  = 2'd0;
    localparam logic [1:0] C_MODE_LFSR  = 2'd1;
    localparam logic [1:0] C_MODE_WALK  = 2'd2;
    localparam logic [1:0] C_MODE_FIXED = 2'd3;

    // Controller state encoding
    localparam int         C_ST_W   = 3;
    localparam logic [C_ST_W-1:0] C_ST_IDLE = 3'd0;
    localparam logic [C_ST_W-1:0] C_ST_WA   = 3'd1;
    localparam logic [C_ST_W-1:0] C_ST_WD   = 3'd2;
    localparam logic [C_ST_W-1:0] C_ST_RA   = 3'd3;
    localparam logic [C_ST_W-1:0] C_ST_RD   = 3'd4;
    localparam logic [C_ST_W-1:0] C_ST_FIN  = 3'd5;

    // x^32 + x^22 + x^2 + x + 1, shifted left with feedback into bit 0
    localparam logic [31:0] C_LFSR_SEED = 32'h0000_0001;
    localparam logic [31:0] C_LFSR_TAPS = 32'h8020_0003;

    function automatic logic [31:0] lfsr_next(input logic [31:0] state);
        return {state[30:0], ^(state & C_LFSR_TAPS)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_mem_traffic_chk_pattern_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mtc_pattern_gen                                                 |
// | Purpose  : Beat-indexed data pattern source. Output is combinational from  |
// |            internal state; restart returns to beat 0 (LFSR reseeded),      |
// |            advance steps to the next beat. restart wins over advance.      |
// | Ports    : clk, rstn        clock, async active-low reset                   |
// |            restart, advance sequencing controls                             |
// |            mode [1:0]      pattern selection                                |
// |            pattern [DATA_W] current beat's data                             |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module mtc_pattern_gen
    import axi_mem_traffic_chk_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              restart,
    input  logic              advance,
    input  logic [1:0]        mode,
    output logic [DATA_W-1:0] pattern
);

    localparam int C_STRB_W = DATA_W / 8;
    localparam int C_NWORDS = (DATA_W + 31) / 32;

    logic [31:0]            r_idx;
    logic [31:0]            r_lfsr;
    logic [DATA_W-1:0]      r_walk;
    logic [31:0]            w_word;
    logic [C_NWORDS*32-1:0] w_rep;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_idx  <= '0;
            r_lfsr <= C_LFSR_SEED;
            r_walk <= DATA_W'(1);
        end else if (restart) begin
            r_idx  <= '0;
            r_lfsr <= C_LFSR_SEED;
            r_walk <= DATA_W'(1);
        end else if (advance) begin
            r_idx  <= r_idx + 32'd1;
            r_lfsr <= lfsr_next(r_lfsr);
            r_walk <= {r_walk[DATA_W-2:0], r_walk[DATA_W-1]};
        end
    end

    assign w_word = (mode == C_MODE_LFSR) ? r_lfsr : r_idx;

    // 32-bit pattern words are repeated across the bus and trimmed to DATA_W
    for (genvar g = 0; g < C_NWORDS; g++) begin : g_rep
        assign w_rep[g*32 +: 32] = w_word;
    end

    always_comb begin
        pattern = {C_STRB_W{8'hA5}};
        case (mode)
            C_MODE_INCR,
            C_MODE_LFSR:  pattern = w_rep[DATA_W-1:0];
            C_MODE_WALK:  pattern = r_walk;
            C_MODE_FIXED: pattern = {C_STRB_W{8'hA5}};
            default:      pattern = {C_STRB_W{8'hA5}};
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/axi_mem_traffic_chk.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : axi_mem_traffic_chk                                             |
// | Purpose  : Memory self-test master. On start writes burst_num bursts of    |
// |            burst_len+1 beats of a selected pattern, reads the region back  |
// |            and compares every beat, reporting pass/fail, error count,      |
// |            first failing byte address and last-beat protocol errors.       |
// | Ports    : clk, rstn                      clock, async active-low reset     |
// |            start, mode, base_addr,        run control (sampled in idle)     |
// |            burst_len, burst_num                                            |
// |            busy, done, pass, err_cnt,     status                            |
// |            first_err_addr, proto_err                                       |
// |            wr_addr/wr_len/valid/ready     write address channel             |
// |            wr_data/strb/valid/last/ready  write data channel                |
// |            rd_addr/rd_len/valid/ready     read address channel              |
// |            rd_data/valid/last/ready       read data channel                 |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module axi_mem_traffic_chk
    import axi_mem_traffic_chk_pkg::*;
#(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8,
    parameter int CNT_W  = 8,
    parameter int ERR_W  = 16
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                start,
    input  logic [1:0]          mode,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [LEN_W-1:0]    burst_len,
    input  logic [CNT_W-1:0]    burst_num,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [ERR_W-1:0]    err_cnt,
    output logic [ADDR_W-1:0]   first_err_addr,
    output logic                proto_err,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [LEN_W-1:0]    wr_len,
    output logic                wr_addr_valid,
    input  logic                wr_addr_ready,
    output logic [DATA_W-1:0]   wr_data,
    output logic [DATA_W/8-1:0] wr_strb,
    output logic                wr_data_valid,
    output logic                wr_data_last,
    input  logic                wr_data_ready,
    output logic [ADDR_W-1:0]   rd_addr,
    output logic [LEN_W-1:0]    rd_len,
    output logic                rd_addr_valid,
    input  logic                rd_addr_ready,
    input  logic [DATA_W-1:0]   rd_data,
    input  logic                rd_data_valid,
    input  logic                rd_data_last,
    output logic                rd_data_ready
);

    localparam int              C_STRB_W  = DATA_W / 8;
    localparam logic [ERR_W-1:0] C_ERR_MAX = {ERR_W{1'b1}};

    logic [C_ST_W-1:0] r_state;
    logic [1:0]        r_mode;
    logic [ADDR_W-1:0] r_base;
    logic [LEN_W-1:0]  r_len;
    logic [CNT_W-1:0]  r_num;
    logic [CNT_W-1:0]  r_burst;
    logic [LEN_W-1:0]  r_beat;
    logic [ADDR_W-1:0] r_addr;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;
    logic [ERR_W-1:0]  r_err_cnt;
    logic [ADDR_W-1:0] r_first_err_addr;
    logic              r_proto_err;

    logic [DATA_W-1:0] w_pattern;
    logic [ADDR_W-1:0] w_step;
    logic [ADDR_W-1:0] w_beat_addr;
    logic              w_beat_last;
    logic              w_burst_last;
    logic              w_wd_xfer;
    logic              w_rd_beat;
    logic              w_mismatch;
    logic              w_last_bad;
    logic              w_pass_nxt;
    logic              w_gen_restart;
    logic              w_gen_advance;

    // Byte distance between consecutive bursts and address of the current beat
    assign w_step       = (ADDR_W'(r_len) + ADDR_W'(1)) * ADDR_W'(C_STRB_W);
    assign w_beat_addr  = r_addr + ADDR_W'(r_beat) * ADDR_W'(C_STRB_W);
    assign w_beat_last  = (r_beat == r_len);
    assign w_burst_last = (r_burst == r_num - CNT_W'(1));

    assign w_wd_xfer  = (r_state == C_ST_WD) && wr_data_ready;
    assign w_rd_beat  = (r_state == C_ST_RD) && rd_data_valid;
    assign w_mismatch = w_rd_beat && (rd_data != w_pattern);
    assign w_last_bad = w_rd_beat && (rd_data_last != w_beat_last);
    assign w_pass_nxt = (r_err_cnt == '0) && !w_mismatch && !r_proto_err && !w_last_bad;

    // The generator is rewound at start and again as the read phase begins,
    // so the read side sees exactly the sequence that was written.
    assign w_gen_restart = ((r_state == C_ST_IDLE) && start) ||
                           (w_wd_xfer && w_beat_last && w_burst_last);
    assign w_gen_advance = w_wd_xfer || w_rd_beat;

    mtc_pattern_gen #(
        .DATA_W (DATA_W)
    ) u_pattern_gen (
        .clk     (clk),
        .rstn    (rstn),
        .restart (w_gen_restart),
        .advance (w_gen_advance),
        .mode    (r_mode),
        .pattern (w_pattern)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state          <= C_ST_IDLE;
            r_mode           <= C_MODE_INCR;
            r_base           <= '0;
            r_len            <= '0;
            r_num            <= '0;
            r_burst          <= '0;
            r_beat           <= '0;
            r_addr           <= '0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_pass           <= 1'b0;
            r_err_cnt        <= '0;
            r_first_err_addr <= '0;
            r_proto_err      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                C_ST_IDLE: begin
                    if (start) begin
                        r_mode           <= mode;
                        r_base           <= base_addr;
                        r_len            <= burst_len;
                        r_num            <= burst_num;
                        r_addr           <= base_addr;
                        r_burst          <= '0;
                        r_beat           <= '0;
                        r_busy           <= 1'b1;
                        r_err_cnt        <= '0;
                        r_first_err_addr <= '0;
                        r_proto_err      <= 1'b0;
                        if (burst_num == '0) begin
                            r_state <= C_ST_FIN;
                            r_done  <= 1'b1;
                            r_pass  <= 1'b1;
                        end else begin
                            r_state <= C_ST_WA;
                            r_pass  <= 1'b0;
                        end
                    end
                end
                C_ST_WA: begin
                    if (wr_addr_ready) begin
                        r_state <= C_ST_WD;
                        r_beat  <= '0;
                    end
                end
                C_ST_WD: begin
                    if (wr_data_ready) begin
                        if (w_beat_last) begin
                            r_beat <= '0;
                            if (w_burst_last) begin
                                r_state <= C_ST_RA;
                                r_addr  <= r_base;
                                r_burst <= '0;
                            end else begin
                                r_state <= C_ST_WA;
                                r_addr  <= r_addr + w_step;
                                r_burst <= r_burst + CNT_W'(1);
                            end
                        end else begin
                            r_beat <= r_beat + LEN_W'(1);
                        end
                    end
                end
                C_ST_RA: begin
                    if (rd_addr_ready) begin
                        r_state <= C_ST_RD;
                    end
                end
                C_ST_RD: begin
                    if (rd_data_valid) begin
                        if (w_mismatch) begin
                            if (r_err_cnt != C_ERR_MAX) begin
                                r_err_cnt <= r_err_cnt + ERR_W'(1);
                            end
                            if (r_err_cnt == '0) begin
                                r_first_err_addr <= w_beat_addr;
                            end
                        end
                        if (w_last_bad) begin
                            r_proto_err <= 1'b1;
                        end
                        // Burst length is governed by the requested beat count,
                        // not by where the slave put its last flag.
                        if (w_beat_last) begin
                            r_beat <= '0;
                            if (w_burst_last) begin
                                r_state <= C_ST_FIN;
                                r_done  <= 1'b1;
                                r_pass  <= w_pass_nxt;
                            end else begin
                                r_state <= C_ST_RA;
                                r_addr  <= r_addr + w_step;
                                r_burst <= r_burst + CNT_W'(1);
                            end
                        end else begin
                            r_beat <= r_beat + LEN_W'(1);
                        end
                    end
                end
                C_ST_FIN: begin
                    r_state <= C_ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= C_ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Channel signals decode straight from the state register so an async
    // reset removes every valid without waiting for a clock edge.
    assign wr_addr_valid = (r_state == C_ST_WA);
    assign wr_addr       = r_addr;
    assign wr_len        = r_len;
    assign wr_data_valid = (r_state == C_ST_WD);
    assign wr_data       = wr_data_valid ? w_pattern : '0;
    assign wr_strb       = {C_STRB_W{wr_data_valid}};
    assign wr_data_last  = wr_data_valid && w_beat_last;
    assign rd_addr_valid = (r_state == C_ST_RA);
    assign rd_addr       = r_addr;
    assign rd_len        = r_len;
    assign rd_data_ready = (r_state == C_ST_RD);

    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_pass;
    assign err_cnt        = r_err_cnt;
    assign first_err_addr = r_first_err_addr;
    assign proto_err      = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_axi_mem_traffic_chk.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_axi_mem_traffic_chk                                          |
// | Purpose  : Directed self-checking bench for axi_mem_traffic_chk. A         |
// |            behavioural slave stores written beats and echoes them back,    |
// |            with optional ready/valid stalls, a flipped read bit and a      |
// |            misplaced read last flag.                                       |
// | Ports    : none                                                            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_axi_mem_traffic_chk;

    localparam int C_BUDGET = 4000;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic [1:0]  mode;
    logic [27:0] base_addr;
    logic [7:0]  burst_len;
    logic [7:0]  burst_num;
    logic        busy, done, pass, proto_err;
    logic [15:0] err_cnt;
    logic [27:0] first_err_addr;
    logic [27:0] wr_addr, rd_addr;
    logic [7:0]  wr_len, rd_len;
    logic        wr_addr_valid, wr_addr_ready;
    logic [31:0] wr_data, rd_data;
    logic [3:0]  wr_strb;
    logic        wr_data_valid, wr_data_last, wr_data_ready;
    logic        rd_addr_valid, rd_addr_ready;
    logic        rd_data_valid, rd_data_last, rd_data_ready;

    axi_mem_traffic_chk u_dut (
        .clk(clk), .rstn(rstn), .start(start), .mode(mode), .base_addr(base_addr),
        .burst_len(burst_len), .burst_num(burst_num), .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt), .first_err_addr(first_err_addr), .proto_err(proto_err),
        .wr_addr(wr_addr), .wr_len(wr_len), .wr_addr_valid(wr_addr_valid), .wr_addr_ready(wr_addr_ready),
        .wr_data(wr_data), .wr_strb(wr_strb), .wr_data_valid(wr_data_valid), .wr_data_last(wr_data_last),
        .wr_data_ready(wr_data_ready), .rd_addr(rd_addr), .rd_len(rd_len), .rd_addr_valid(rd_addr_valid),
        .rd_addr_ready(rd_addr_ready), .rd_data(rd_data), .rd_data_valid(rd_data_valid),
        .rd_data_last(rd_data_last), .rd_data_ready(rd_data_ready)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Slave / scoreboard state
    logic [1:0]  cfg_mode;
    int          cfg_len, cfg_num, cfg_flip, cfg_early;
    bit          cfg_stall;
    logic [27:0] step, exp_wa, exp_ra, wa_cur, ra_cur, wa_hold_addr, ra_hold_addr;
    logic [7:0]  wa_hold_len, ra_hold_len;
    logic [37:0] wd_hold;
    bit          wa_stalled, wd_stalled, ra_stalled, rd_active;
    int          wbeat, rbeat, wgidx, rgidx, n_wa, n_ra, n_wb, n_rb, n_valid_seen;
    logic [31:0] m_lfsr;
    logic [31:0] mem [logic [27:0]];

    task automatic slave_clear();
        wa_stalled = 0; wd_stalled = 0; ra_stalled = 0; rd_active = 0;
        wbeat = 0; rbeat = 0; wgidx = 0; rgidx = 0;
        n_wa = 0; n_ra = 0; n_wb = 0; n_rb = 0; n_valid_seen = 0;
        m_lfsr = 32'h1;
        mem.delete();
        wr_addr_ready = 0; wr_data_ready = 0; rd_addr_ready = 0;
        rd_data_valid = 0; rd_data_last = 0; rd_data = '0;
    endtask

    function automatic bit pick_ready();
        return cfg_stall ? 1'($urandom_range(0, 1)) : 1'b1;
    endfunction

    // Called once per cycle at the falling edge: DUT outputs are settled and
    // the inputs driven here are what the next rising edge sees.
    task automatic slave_step();
        logic [31:0] e;
        logic [31:0] d;
        logic [27:0] a;
        // write address channel
        if (wa_stalled)
            chk("wa_hold", 64'({wr_addr_valid, wr_len, wr_addr}), 64'({1'b1, wa_hold_len, wa_hold_addr}));
        wa_stalled = 0;
        wr_addr_ready = pick_ready();
        if (wr_addr_valid) begin
            if (wr_addr_ready) begin
                chk("wa_addr", 64'(wr_addr), 64'(exp_wa));
                chk("wa_len", 64'(wr_len), 64'(cfg_len));
                wa_cur = wr_addr; exp_wa = exp_wa + step; wbeat = 0; n_wa++;
            end else begin
                wa_stalled = 1; wa_hold_addr = wr_addr; wa_hold_len = wr_len;
            end
        end
        // write data channel
        if (wd_stalled)
            chk("wd_hold", 64'({wr_data_valid, wr_data_last, wr_strb, wr_data}), 64'(wd_hold));
        wd_stalled = 0;
        wr_data_ready = pick_ready();
        if (wr_data_valid) begin
            if (wr_data_ready) begin
                case (cfg_mode)
                    2'd0:    e = 32'(wgidx);
                    2'd1:    e = m_lfsr;
                    2'd2:    e = 32'h1 << (wgidx % 32);
                    default: e = 32'hA5A5_A5A5;
                endcase
                chk("wd_data", 64'(wr_data), 64'(e));
                chk("wd_last", 64'(wr_data_last), 64'(wbeat == cfg_len));
                chk("wd_strb", 64'(wr_strb), 64'hF);
                mem[wa_cur + 28'(wbeat * 4)] = wr_data;
                m_lfsr = {m_lfsr[30:0], m_lfsr[31] ^ m_lfsr[21] ^ m_lfsr[1] ^ m_lfsr[0]};
                wbeat++; wgidx++; n_wb++;
            end else begin
                wd_stalled = 1; wd_hold = {wr_data_valid, wr_data_last, wr_strb, wr_data};
            end
        end
        // read data channel (before address so data starts the cycle after)
        rd_data_valid = 0; rd_data_last = 0; rd_data = '0;
        if (rd_active && pick_ready()) begin
            a = ra_cur + 28'(rbeat * 4);
            d = mem.exists(a) ? mem[a] : 32'h0;
            if (rgidx == cfg_flip) d = d ^ 32'h1;
            rd_data_valid = 1;
            rd_data = d;
            rd_data_last = (cfg_early >= 0) ? (rbeat == cfg_early) : (rbeat == cfg_len);
            if (rd_data_ready) begin
                n_rb++; rgidx++;
                if (rbeat == cfg_len) rd_active = 0;
                else rbeat++;
            end
        end
        // read address channel
        if (ra_stalled)
            chk("ra_hold", 64'({rd_addr_valid, rd_len, rd_addr}), 64'({1'b1, ra_hold_len, ra_hold_addr}));
        ra_stalled = 0;
        rd_addr_ready = pick_ready();
        if (rd_addr_valid) begin
            if (rd_addr_ready) begin
                chk("ra_addr", 64'(rd_addr), 64'(exp_ra));
                chk("ra_len", 64'(rd_len), 64'(cfg_len));
                ra_cur = rd_addr; exp_ra = exp_ra + step; rbeat = 0; rd_active = 1; n_ra++;
            end else begin
                ra_stalled = 1; ra_hold_addr = rd_addr; ra_hold_len = rd_len;
            end
        end
    endtask

    task automatic setup(input logic [1:0] m, input logic [27:0] base, input int len, input int num,
                         input bit stall, input int flip, input int early);
        slave_clear();
        cfg_mode = m; cfg_len = len; cfg_num = num; cfg_stall = stall;
        cfg_flip = flip; cfg_early = early;
        step = 28'((len + 1) * 4);
        exp_wa = base; exp_ra = base;
        mode = m; base_addr = base; burst_len = 8'(len); burst_num = 8'(num);
    endtask

    task automatic do_run(input logic [1:0] m, input logic [27:0] base, input int len, input int num,
                          input bit stall, input int flip, input int early, input int mid,
                          output int done_cyc);
        int cyc;
        @(negedge clk);
        setup(m, base, len, num, stall, flip, early);
        start = 1;
        @(negedge clk);
        start = 0;
        cyc = 1;
        done_cyc = -1;
        while (cyc < C_BUDGET) begin
            if (wr_addr_valid || wr_data_valid || rd_addr_valid) n_valid_seen++;
            if (done) begin
                done_cyc = cyc;
                break;
            end
            slave_step();
            start = (mid > 0 && cyc == mid);
            @(negedge clk);
            cyc++;
        end
        start = 0;
        wr_addr_ready = 0; wr_data_ready = 0; rd_addr_ready = 0;
        rd_data_valid = 0; rd_data_last = 0;
        chk("run_done", 64'(done), 64'd1);
    endtask

    task automatic check_end(input string p, input bit e_pass, input int e_err,
                             input logic [27:0] e_first, input bit e_proto);
        chk({p, "_busy_at_done"}, 64'(busy), 64'd1);
        chk({p, "_pass"}, 64'(pass), 64'(e_pass));
        chk({p, "_err_cnt"}, 64'(err_cnt), 64'(e_err));
        chk({p, "_first_err"}, 64'(first_err_addr), 64'(e_first));
        chk({p, "_proto"}, 64'(proto_err), 64'(e_proto));
        chk({p, "_n_wa"}, 64'(n_wa), 64'(cfg_num));
        chk({p, "_n_ra"}, 64'(n_ra), 64'(cfg_num));
        chk({p, "_n_wbeats"}, 64'(n_wb), 64'(cfg_num * (cfg_len + 1)));
        chk({p, "_n_rbeats"}, 64'(n_rb), 64'(cfg_num * (cfg_len + 1)));
        @(negedge clk);
        if (wr_addr_valid || wr_data_valid || rd_addr_valid) n_valid_seen++;
        chk({p, "_busy_after"}, 64'(busy), 64'd0);
        chk({p, "_done_pulse"}, 64'(done), 64'd0);
        chk({p, "_pass_held"}, 64'(pass), 64'(e_pass));
    endtask

    initial begin
        int dc;
        rstn = 0; start = 0; mode = 0; base_addr = '0; burst_len = '0; burst_num = '0;
        cfg_stall = 0;
        slave_clear();
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_pass", 64'(pass), 64'd0);
        chk("rst_err_cnt", 64'(err_cnt), 64'd0);
        chk("rst_first_err", 64'(first_err_addr), 64'd0);
        chk("rst_proto", 64'(proto_err), 64'd0);
        chk("rst_valids", 64'({wr_addr_valid, wr_data_valid, rd_addr_valid, rd_data_ready}), 64'd0);
        chk("rst_wdata_strb", 64'({wr_strb, wr_data}), 64'd0);
        rstn = 1;

        // incrementing data, two full-size bursts, ideal slave
        do_run(2'd0, 28'h0, 255, 2, 0, -1, -1, 0, dc);
        check_end("incr", 1, 0, 28'h0, 0);

        // LFSR data, read beat 10 corrupted -> one error at byte 0x28
        do_run(2'd1, 28'h0, 15, 2, 0, 10, -1, 0, dc);
        check_end("lfsr_flip", 0, 1, 28'h28, 0);

        // walking ones with random stalls on every channel, region wraps the address space
        do_run(2'd2, 28'hFFF_FF00, 15, 8, 1, -1, -1, 0, dc);
        check_end("walk_stall", 1, 0, 28'h0, 0);

        // zero bursts: straight to completion, nothing issued
        do_run(2'd3, 28'h200, 3, 0, 0, -1, -1, 0, dc);
        chk("n0_done_latency", 64'(dc), 64'd1);
        check_end("n0", 1, 0, 28'h0, 0);
        chk("n0_no_valid", 64'(n_valid_seen), 64'd0);

        // fixed pattern, slave places last on beat 3 of 8; start pulse mid-run ignored
        do_run(2'd3, 28'h1000, 7, 1, 0, -1, 3, 6, dc);
        check_end("early_last", 0, 0, 28'h0, 1);

        // reset while write data is flowing, then a clean run
        @(negedge clk);
        setup(2'd0, 28'h40, 15, 2, 0, -1, -1);
        start = 1;
        @(negedge clk);
        start = 0;
        for (int i = 0; i < 200; i++) begin
            if (wr_data_valid && wbeat >= 3) break;
            slave_step();
            @(negedge clk);
        end
        chk("rst_mid_in_wd", 64'(wr_data_valid), 64'd1);
        rstn = 0;
        #1;
        chk("rst_mid_wd_valid", 64'(wr_data_valid), 64'd0);
        chk("rst_mid_valids", 64'({wr_addr_valid, rd_addr_valid, rd_data_ready}), 64'd0);
        chk("rst_mid_busy_done", 64'({busy, done}), 64'd0);
        slave_clear();
        repeat (2) @(negedge clk);
        rstn = 1;
        do_run(2'd0, 28'h40, 15, 2, 0, -1, -1, 0, dc);
        check_end("after_rst", 1, 0, 28'h0, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
